triple_packer: RTL

Stream-to-triple packer placed directly upstream of the 3-input sorting stage. Accepts a byte stream on a valid/ready interface and groups consecutive bytes into (a, b, c) triples. Delivers each triple as one registered word on a second valid/ready interface whose a/b/c fields wire straight to the sorter inputs. A short final group, marked by in_last, is padded and flagged so the consumer can discard filler lanes.

---
 rtl/triple_pkg.sv | 24 ++
 rtl/triple_packer_if.sv | 27 ++
 rtl/triple_out_reg.sv | 33 +++
 rtl/triple_packer.sv | 99 +++++++++
 4 files changed

// File: rtl/triple_pkg.sv
// Shared types and defaults for the stream-to-triple packer feeding the 3-input sorter.
package triple_pkg;

    localparam int TP_WIDTH = 8;
    localparam logic [TP_WIDTH-1:0] TP_PAD_VAL = 8'h00;

    typedef struct packed {
        logic [TP_WIDTH-1:0] a;
        logic [TP_WIDTH-1:0] b;
        logic [TP_WIDTH-1:0] c;
    } triple_t;

    typedef enum logic [1:0] {
        FILL0 = 2'd0,
        FILL1 = 2'd1,
        FILL2 = 2'd2
    } fill_e;

    // An element closes its group either as the third lane or when flagged last.
    function automatic logic closes_group(fill_e fill, logic last);
        return (fill == FILL2) || last;
    endfunction

endpackage

// File: rtl/triple_packer_if.sv
// Byte-stream input and triple output handshakes of the packer, bundled as one interface.
interface triple_packer_if #(
    parameter int WIDTH = triple_pkg::TP_WIDTH
);
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_last;
    logic             in_ready;
    logic [WIDTH-1:0] out_a;
    logic [WIDTH-1:0] out_b;
    logic [WIDTH-1:0] out_c;
    logic [1:0]       out_count;
    logic             out_valid;
    logic             out_ready;

    // master: the environment (producer upstream, sorter downstream)
    modport master (
        output in_data, in_valid, in_last, out_ready,
        input  in_ready, out_a, out_b, out_c, out_count, out_valid
    );

    // slave: the packer itself
    modport slave (
        input  in_data, in_valid, in_last, out_ready,
        output in_ready, out_a, out_b, out_c, out_count, out_valid
    );
endinterface

// File: rtl/triple_out_reg.sv
// Output holding register: loads a finished triple on launch, holds it while the sorter stalls.
module triple_out_reg
    import triple_pkg::*;
#(
    parameter logic [TP_WIDTH-1:0] PAD_VAL = TP_PAD_VAL
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       launch,
    input  triple_t    load_triple,
    input  logic [1:0] load_count,
    input  logic       out_ready,
    output triple_t    out_triple,
    output logic [1:0] out_count,
    output logic       out_valid
);

    // The top only launches into a free slot, so a launch always wins over a drain.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_triple <= '{a: PAD_VAL, b: PAD_VAL, c: PAD_VAL};
            out_count  <= 2'd0;
            out_valid  <= 1'b0;
        end else if (launch) begin
            out_triple <= load_triple;
            out_count  <= load_count;
            out_valid  <= 1'b1;
        end else if (out_ready) begin
            out_valid  <= 1'b0;
        end
    end

endmodule

// File: rtl/triple_packer.sv
// Groups a byte stream into padded (a, b, c) triples for the sorter; short groups end on in_last.
module triple_packer
    import triple_pkg::*;
#(
    parameter int WIDTH = TP_WIDTH,
    parameter logic [WIDTH-1:0] PAD_VAL = TP_PAD_VAL
) (
    input logic            clk,
    input logic            rst_n,
    triple_packer_if.slave bus
);

    fill_e            cnt;
    logic [WIDTH-1:0] stage_a;
    logic [WIDTH-1:0] stage_b;
    logic             completes;
    logic             in_ready;
    logic             accept;
    logic             launch;
    triple_t          next_triple;
    logic [1:0]       next_count;
    triple_t          out_triple;
    logic [1:0]       out_count;
    logic             out_valid;

    // Only a completing element needs the output slot; staging elements never stall.
    assign completes = closes_group(cnt, bus.in_last);
    assign in_ready  = !(completes && out_valid && !bus.out_ready);
    assign accept    = bus.in_valid && in_ready;
    assign launch    = accept && completes;

    always_comb begin
        next_triple = '{a: stage_a, b: stage_b, c: bus.in_data};
        next_count  = 2'd3;
        if (bus.in_last) begin
            case (cnt)
                FILL0: begin
                    next_triple = '{a: bus.in_data, b: PAD_VAL, c: PAD_VAL};
                    next_count  = 2'd1;
                end
                FILL1: begin
                    next_triple = '{a: stage_a, b: bus.in_data, c: PAD_VAL};
                    next_count  = 2'd2;
                end
                default: begin
                    next_triple = '{a: stage_a, b: stage_b, c: bus.in_data};
                    next_count  = 2'd3;
                end
            endcase
        end
    end

    // Fill-state machine; staged lanes are simply overwritten by the next group.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt     <= FILL0;
            stage_a <= PAD_VAL;
            stage_b <= PAD_VAL;
        end else if (accept) begin
            if (completes) begin
                cnt <= FILL0;
            end else begin
                case (cnt)
                    FILL0: begin
                        stage_a <= bus.in_data;
                        cnt     <= FILL1;
                    end
                    FILL1: begin
                        stage_b <= bus.in_data;
                        cnt     <= FILL2;
                    end
                    default: cnt <= FILL0;
                endcase
            end
        end
    end

    triple_out_reg #(
        .PAD_VAL (PAD_VAL)
    ) u_out_reg (
        .clk         (clk),
        .rst_n       (rst_n),
        .launch      (launch),
        .load_triple (next_triple),
        .load_count  (next_count),
        .out_ready   (bus.out_ready),
        .out_triple  (out_triple),
        .out_count   (out_count),
        .out_valid   (out_valid)
    );

    assign bus.in_ready  = in_ready;
    assign bus.out_a     = out_triple.a;
    assign bus.out_b     = out_triple.b;
    assign bus.out_c     = out_triple.c;
    assign bus.out_count = out_count;
    assign bus.out_valid = out_valid;

endmodule
